// File: rtl/ysyx_210184_mem_arbiter_if.sv
// Bundle of requester-side (IF / MEM stage) and memory-side signals of the
// shared external memory port. The arbiter takes the slave view; the
// environment driving requests and the memory model takes the master view.
interface ysyx_210184_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // Instruction fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_data;

  // MEM stage side (mem_ready / mem_rdata are MAC_ready / MAC_data)
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_size;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  // External memory side
  logic              bus_valid;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [1:0]        bus_size;
  logic              bus_ready;
  logic [DATA_W-1:0] bus_rdata;

  logic              grant_mem;

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    input  bus_ready, bus_rdata,
    output if_ready, if_data,
    output mem_ready, mem_rdata,
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_size,
    output grant_mem
  );

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    output bus_ready, bus_rdata,
    input  if_ready, if_data,
    input  mem_ready, mem_rdata,
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_size,
    input  grant_mem
  );
endinterface

// File: rtl/ysyx_210184_mem_arbiter.sv
// Arbiter sharing one external memory port between instruction fetch and the
// MEM stage. One owner at a time, bus request held stable until the memory
// acknowledges, then a single-cycle ready pulse back to the owner. MEM wins
// ties unless IF has already lost STARVE_MAX consecutive arbitrations.
module ysyx_210184_mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 2
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_210184_mem_arbiter_if.slave io
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUS_IF  = 2'd1,
    S_BUS_MEM = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   starve_q,    starve_d;
  logic               bus_valid_q, bus_valid_d;
  logic               bus_we_q,    bus_we_d;
  logic [ADDR_W-1:0]  bus_addr_q,  bus_addr_d;
  logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;
  logic [1:0]         bus_size_q,  bus_size_d;
  logic               grant_mem_q, grant_mem_d;
  logic               if_ready_q,  if_ready_d;
  logic               mem_ready_q, mem_ready_d;
  logic [DATA_W-1:0]  if_data_q,   if_data_d;
  logic [DATA_W-1:0]  mem_rdata_q, mem_rdata_d;

  logic take_if;

  // Next-state, arbitration and output computation for the whole arbiter.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    starve_d    = starve_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_size_d  = bus_size_q;
    grant_mem_d = grant_mem_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    take_if     = io.if_req && (!io.mem_req || (starve_q >= STARVE_LIM));

    case (state_q)
      S_IDLE: begin
        if (take_if) begin
          state_d     = S_BUS_IF;
          bus_valid_d = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = io.if_addr;
          bus_wdata_d = '0;
          bus_size_d  = 2'd3;
          grant_mem_d = 1'b0;
          starve_d    = '0;
        end else if (io.mem_req) begin
          state_d     = S_BUS_MEM;
          bus_valid_d = 1'b1;
          bus_we_d    = io.mem_we;
          bus_addr_d  = io.mem_addr;
          bus_wdata_d = io.mem_wdata;
          bus_size_d  = io.mem_size;
          grant_mem_d = 1'b1;
          // Count only MEM wins that made a waiting IF request lose.
          if (!io.if_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end else begin
          starve_d = '0;
        end
      end

      S_BUS_IF: begin
        if (io.bus_ready) begin
          state_d     = S_RESP;
          bus_valid_d = 1'b0;
          if_data_d   = io.bus_rdata;
          if_ready_d  = 1'b1;
        end
      end

      S_BUS_MEM: begin
        if (io.bus_ready) begin
          state_d     = S_RESP;
          bus_valid_d = 1'b0;
          mem_ready_d = 1'b1;
          // Stores return no data; keep the last load result visible.
          if (!bus_we_q) begin
            mem_rdata_d = io.bus_rdata;
          end
        end
      end

      // One-cycle response slot; requests are deliberately not arbitrated
      // here so a req still high from the finished transfer is not re-issued.
      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_size_q  <= '0;
      grant_mem_q <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      starve_q    <= starve_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_size_q  <= bus_size_d;
      grant_mem_q <= grant_mem_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign io.bus_valid = bus_valid_q;
  assign io.bus_we    = bus_we_q;
  assign io.bus_addr  = bus_addr_q;
  assign io.bus_wdata = bus_wdata_q;
  assign io.bus_size  = bus_size_q;
  assign io.grant_mem = grant_mem_q;
  assign io.if_ready  = if_ready_q;
  assign io.if_data   = if_data_q;
  assign io.mem_ready = mem_ready_q;
  assign io.mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_ysyx_210184_mem_arbiter.sv
// Bench for the memory arbiter: directed scenarios with literal expectations,
// then randomized requesters and memory, all checked every cycle against a
// transaction-level model of the arbitration rules.
module tb_ysyx_210184_mem_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int SMAX = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ysyx_210184_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  ysyx_210184_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bif.slave)
  );

  always #5 clk = ~clk;

  // Expected outputs, derived from the arbitration rules.
  typedef struct {
    logic          bus_valid;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [1:0]    bus_size;
    logic          grant_mem;
    logic          if_ready;
    logic          mem_ready;
    logic [DW-1:0] if_data;
    logic [DW-1:0] mem_rdata;
  } exp_t;

  exp_t m;
  int   starve;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   auto_on     = 1'b0;
  bit   if_pend, if_stale, mem_pend, mem_stale;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m.bus_valid = 0; m.bus_we = 0; m.bus_addr = '0; m.bus_wdata = '0;
    m.bus_size = '0; m.grant_mem = 0; m.if_ready = 0; m.mem_ready = 0;
    m.if_data = '0; m.mem_rdata = '0;
    starve = 0;
  endtask

  // Advances the model by the clock edge just passed. Inputs only change at
  // negedges, so the values seen now are the ones that edge sampled.
  task automatic model_advance();
    bit pick_if;
    if (rst) begin
      model_clear();
    end else if (m.if_ready || m.mem_ready) begin
      // response slot just ended; nothing is arbitrated on this edge
      m.if_ready  = 0;
      m.mem_ready = 0;
    end else if (m.bus_valid) begin
      if (bif.bus_ready) begin
        m.bus_valid = 0;
        if (m.grant_mem) begin
          m.mem_ready = 1;
          if (!m.bus_we) m.mem_rdata = bif.bus_rdata;
        end else begin
          m.if_ready = 1;
          m.if_data  = bif.bus_rdata;
        end
      end
    end else begin
      pick_if = bif.if_req && (!bif.mem_req || starve >= SMAX);
      if (pick_if) begin
        m.bus_valid = 1; m.grant_mem = 0; m.bus_we = 0;
        m.bus_addr = bif.if_addr; m.bus_wdata = '0; m.bus_size = 2'd3;
        starve = 0;
      end else if (bif.mem_req) begin
        m.bus_valid = 1; m.grant_mem = 1; m.bus_we = bif.mem_we;
        m.bus_addr = bif.mem_addr; m.bus_wdata = bif.mem_wdata; m.bus_size = bif.mem_size;
        starve = bif.if_req ? ((starve + 1 > SMAX) ? SMAX : starve + 1) : 0;
      end else begin
        starve = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("bus_valid", bif.bus_valid, m.bus_valid);
    check("bus_we",    bif.bus_we,    m.bus_we);
    check("bus_addr",  bif.bus_addr,  m.bus_addr);
    check("bus_wdata", bif.bus_wdata, m.bus_wdata);
    check("bus_size",  bif.bus_size,  m.bus_size);
    check("grant_mem", bif.grant_mem, m.grant_mem);
    check("if_ready",  bif.if_ready,  m.if_ready);
    check("mem_ready", bif.mem_ready, m.mem_ready);
    check("if_data",   bif.if_data,   m.if_data);
    check("mem_rdata", bif.mem_rdata, m.mem_rdata);
    check("one_ready", bif.if_ready & bif.mem_ready, 1'b0);
  endtask

  // Random requesters (req held until ready, sometimes one stale cycle more)
  // and a random memory that may raise bus_ready at any time.
  task automatic drive_random();
    bif.bus_ready = ($urandom_range(0, 2) == 0);
    bif.bus_rdata = {$urandom, $urandom};

    if (if_stale) begin
      bif.if_req = 0; if_stale = 0; if_pend = 0;
    end else if (if_pend) begin
      if (bif.if_ready) begin
        if ($urandom_range(0, 1) == 1) if_stale = 1;
        else begin bif.if_req = 0; if_pend = 0; end
      end
    end else if ($urandom_range(0, 2) == 0) begin
      bif.if_req = 1; if_pend = 1;
    end
    bif.if_addr = {$urandom, $urandom};

    if (mem_stale) begin
      bif.mem_req = 0; mem_stale = 0; mem_pend = 0;
    end else if (mem_pend) begin
      if (bif.mem_ready) begin
        if ($urandom_range(0, 1) == 1) mem_stale = 1;
        else begin bif.mem_req = 0; mem_pend = 0; end
      end
    end else if ($urandom_range(0, 1) == 0) begin
      bif.mem_req = 1; mem_pend = 1;
    end
    bif.mem_we    = $urandom_range(0, 1) == 1;
    bif.mem_addr  = {$urandom, $urandom};
    bif.mem_wdata = {$urandom, $urandom};
    bif.mem_size  = 2'($urandom_range(0, 3));
  endtask

  task automatic step();
    @(negedge clk);
    model_advance();
    compare_all();
    if (auto_on) drive_random();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bif.bus_valid && n < 20) begin step(); n++; end
    check(name, bif.bus_valid, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            exp_order [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit            got_order [$];
    logic          prev_valid;
    int            n;
    logic [DW-1:0] rd;

    bif.if_req = 0; bif.if_addr = '0;
    bif.mem_req = 0; bif.mem_we = 0; bif.mem_addr = '0; bif.mem_wdata = '0; bif.mem_size = '0;
    bif.bus_ready = 0; bif.bus_rdata = '0;
    if_pend = 0; if_stale = 0; mem_pend = 0; mem_stale = 0;
    model_clear();

    // Reset state
    #1 rst = 1;
    step(); step();
    check("rst_bus_valid", bif.bus_valid, 1'b0);
    check("rst_mem_rdata", bif.mem_rdata, 64'h0);
    rst = 0;

    // Reset during a MEM transfer abandons it
    bif.mem_req = 1; bif.mem_we = 1; bif.mem_addr = 64'h8000_2000;
    bif.mem_wdata = 64'h55; bif.mem_size = 2'd3;
    step();
    check("t1_granted", bif.bus_valid, 1'b1);
    step();
    #2 rst = 1;
    #1 check("t1_rst_drops_valid", bif.bus_valid, 1'b0);
    bif.mem_req = 0;
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_no_ready", bif.mem_ready, 1'b0);
    end

    // Next MEM load served normally; req held one stale cycle after ready
    bif.mem_req = 1; bif.mem_we = 0; bif.mem_addr = 64'h8000_1000; bif.mem_size = 2'd3;
    step();
    check("t5_load_granted", bif.bus_valid, 1'b1);
    bif.bus_ready = 1; bif.bus_rdata = 64'h1111_2222_3333_4444;
    step();
    check("t5_mem_ready", bif.mem_ready, 1'b1);
    check("t5_mem_rdata", bif.mem_rdata, 64'h1111_2222_3333_4444);
    bif.bus_ready = 0;
    step();
    check("t5_ready_pulse", bif.mem_ready, 1'b0);
    bif.mem_req = 0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bif.bus_valid) n++;
    end
    check("t5_no_reissue", 32'(n), 32'd0);

    // IF only, acked after 3 cycles; IF address changes are ignored
    bif.if_req = 1; bif.if_addr = 64'h8000_0000;
    step();
    for (int i = 0; i < 3; i++) begin
      check("t2_valid", bif.bus_valid, 1'b1);
      check("t2_we",    bif.bus_we, 1'b0);
      check("t2_size",  bif.bus_size, 2'd3);
      check("t2_addr",  bif.bus_addr, 64'h8000_0000);
      check("t2_grant", bif.grant_mem, 1'b0);
      bif.if_addr = {$urandom, $urandom};
      if (i == 2) begin bif.bus_ready = 1; bif.bus_rdata = 64'h0000_0013_0000_0093; end
      step();
    end
    check("t2_if_ready",  bif.if_ready, 1'b1);
    check("t2_if_data",   bif.if_data, 64'h0000_0013_0000_0093);
    check("t2_mem_ready", bif.mem_ready, 1'b0);
    bif.if_req = 0; bif.bus_ready = 0;
    step();
    check("t2_pulse_end", bif.if_ready, 1'b0);
    check("t2_data_held", bif.if_data, 64'h0000_0013_0000_0093);

    // MEM store acked in the first bus cycle
    bif.mem_req = 1; bif.mem_we = 1; bif.mem_addr = 64'h8000_1008;
    bif.mem_wdata = 64'hDEAD_BEEF; bif.mem_size = 2'd2;
    step();
    check("t3_we",    bif.bus_we, 1'b1);
    check("t3_size",  bif.bus_size, 2'd2);
    check("t3_addr",  bif.bus_addr, 64'h8000_1008);
    check("t3_wdata", bif.bus_wdata, 64'hDEAD_BEEF);
    check("t3_grant", bif.grant_mem, 1'b1);
    bif.bus_ready = 1; bif.bus_rdata = 64'hFFFF_0000_FFFF_0000;
    step();
    check("t3_mem_ready", bif.mem_ready, 1'b1);
    check("t3_rdata_kept", bif.mem_rdata, 64'h1111_2222_3333_4444);
    bif.mem_req = 0; bif.bus_ready = 0;
    step(); step();

    // IF drops req after grant; the transfer still completes
    bif.if_req = 1; bif.if_addr = 64'h8000_0040;
    wait_valid("t6_granted");
    bif.if_req = 0;
    step(); step();
    rd = 64'hCAFE_F00D_1234_5678;
    bif.bus_ready = 1; bif.bus_rdata = rd;
    step();
    check("t6_if_ready", bif.if_ready, 1'b1);
    check("t6_if_data",  bif.if_data, rd);
    bif.bus_ready = 0;
    step(); step();

    // Both requesters held continuously, each transfer acked after one cycle
    bif.if_req = 1; bif.mem_req = 1; bif.mem_we = 0; bif.mem_size = 2'd3;
    prev_valid = 0;
    n = 0;
    while (got_order.size() < 6 && n < 60) begin
      step();
      if (bif.bus_valid && !prev_valid) got_order.push_back(bif.grant_mem);
      prev_valid = bif.bus_valid;
      bif.bus_ready = bif.bus_valid;
      bif.bus_rdata = {$urandom, $urandom};
      n++;
    end
    check("t4_grants_seen", 32'(got_order.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_order.size()) check($sformatf("t4_order%0d", i), got_order[i], exp_order[i]);
    end
    bif.if_req = 0; bif.mem_req = 0; bif.bus_ready = 0;
    n = 0;
    while ((bif.bus_valid || bif.if_ready || bif.mem_ready) && n < 10) begin
      bif.bus_ready = bif.bus_valid;
      step();
      n++;
    end
    bif.bus_ready = 0;
    step(); step();

    // Randomized traffic with occasional resets
    auto_on = 1;
    for (int i = 0; i < 4000; i++) begin
      step();
      if ($urandom_range(0, 399) == 0) begin
        rst = 1;
        bif.if_req = 0; bif.mem_req = 0;
        if_pend = 0; if_stale = 0; mem_pend = 0; mem_stale = 0;
        step();
        rst = 0;
      end
    end
    auto_on = 0;
    bif.if_req = 0; bif.mem_req = 0; bif.bus_ready = 1;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
